// File: rtl/cache_pkg.sv
// Shared sizes, FSM state encoding and requester ids for the cache miss handler.
package cache_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned OFFSET_W   = 3;
    localparam int unsigned LINE_WORDS = 8;
    localparam int unsigned LINE_W     = LINE_WORDS * DATA_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic REQ_DC = 1'b0;
    localparam logic REQ_IC = 1'b1;

endpackage

// File: rtl/cache_line_buffer.sv
// 8x16 line register file: bulk load of a victim line, indexed word write on read-ack,
// word read for write-back and a flat view of the whole line.
module cache_line_buffer
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [LINE_W-1:0]   load_line,
    input  logic                wr_en,
    input  logic [OFFSET_W-1:0] idx,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_word,
    output logic [LINE_W-1:0]   line
);

    logic [DATA_W-1:0] mem_q [LINE_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_q[i] <= load_line[i*DATA_W +: DATA_W];
            end
        end else if (wr_en) begin
            mem_q[idx] <= wr_data;
        end
    end

    assign rd_word = mem_q[idx];

    always_comb begin
        line = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/cache_miss_handler.sv
// Miss/refill engine shared by dcache and icache: round-robin arbitration, optional
// dirty-victim write-back, word-by-word line fetch and a one-cycle fill pulse.
module cache_miss_handler
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dc_miss_req,
    input  logic [ADDR_W-1:0]   dc_miss_addr,
    input  logic                dc_wb_valid,
    input  logic [ADDR_W-1:0]   dc_wb_addr,
    input  logic [LINE_W-1:0]   dc_wb_line,
    input  logic                ic_miss_req,
    input  logic [ADDR_W-1:0]   ic_miss_addr,
    output logic                fill_valid,
    output logic                fill_to_dc,
    output logic [ADDR_W-1:0]   fill_addr,
    output logic [LINE_W-1:0]   fill_line,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [1:0]          state_q, state_d;
    logic [OFFSET_W-1:0] word_cnt_q, word_cnt_d;
    logic                last_grant_q, req_id_q;
    logic [ADDR_W-1:0]   miss_addr_q, wb_addr_q;
    logic [LINE_W-1:0]   fill_line_q;
    logic [ADDR_W-1:0]   fill_addr_q;
    logic                fill_to_dc_q;

    logic                pick_dc, grant, ack, last_word;
    logic [ADDR_W-1:0]   phase_base, line_base;
    logic [DATA_W-1:0]   buf_word;
    logic [LINE_W-1:0]   buf_line;

    // DC wins when alone or when IC was granted last
    assign pick_dc   = dc_miss_req && (!ic_miss_req || last_grant_q == REQ_IC);
    assign grant     = (state_q == ST_IDLE) && (dc_miss_req || ic_miss_req);
    assign mem_req   = (state_q == ST_WB) || (state_q == ST_RD);
    assign ack       = mem_req && mem_ack;
    assign last_word = &word_cnt_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        unique case (state_q)
            ST_IDLE: if (grant) state_d = (pick_dc && dc_wb_valid) ? ST_WB : ST_RD;
            ST_WB, ST_RD: begin
                if (ack) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (last_word) state_d = (state_q == ST_WB) ? ST_RD : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            last_grant_q <= REQ_IC;
            req_id_q     <= REQ_DC;
            miss_addr_q  <= '0;
            wb_addr_q    <= '0;
            fill_line_q  <= '0;
            fill_addr_q  <= '0;
            fill_to_dc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            if (grant) begin
                last_grant_q <= pick_dc ? REQ_DC : REQ_IC;
                req_id_q     <= pick_dc ? REQ_DC : REQ_IC;
                miss_addr_q  <= pick_dc ? dc_miss_addr : ic_miss_addr;
                wb_addr_q    <= dc_wb_addr;
            end
            // Snapshot the fill so it survives the next refill overwriting the buffer
            if (state_q == ST_DONE) begin
                fill_line_q  <= buf_line;
                fill_addr_q  <= line_base;
                fill_to_dc_q <= (req_id_q == REQ_DC);
            end
        end
    end

    cache_line_buffer u_line_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (grant && pick_dc && dc_wb_valid),
        .load_line (dc_wb_line),
        .wr_en     ((state_q == ST_RD) && ack),
        .idx       (word_cnt_q),
        .wr_data   (mem_rdata),
        .rd_word   (buf_word),
        .line      (buf_line)
    );

    assign line_base  = {miss_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign phase_base = (state_q == ST_WB) ? wb_addr_q : miss_addr_q;

    assign busy       = (state_q != ST_IDLE);
    assign fill_valid = (state_q == ST_DONE);
    assign fill_line  = fill_valid ? buf_line : fill_line_q;
    assign fill_addr  = fill_valid ? line_base : fill_addr_q;
    assign fill_to_dc = fill_valid ? (req_id_q == REQ_DC) : fill_to_dc_q;
    assign mem_we     = (state_q == ST_WB);
    assign mem_addr   = mem_req ? {phase_base[ADDR_W-1:OFFSET_W], word_cnt_q} : '0;
    assign mem_wdata  = mem_we ? buf_word : '0;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: directed and random misses against a transaction-level
// model (expected memory transfer list, round-robin winner, expected fill line).
module tb_cache_miss_handler;

    logic         clk;
    logic         rst_n;
    logic         dc_miss_req, dc_wb_valid, ic_miss_req;
    logic [15:0]  dc_miss_addr, dc_wb_addr, ic_miss_addr;
    logic [127:0] dc_wb_line;
    logic         fill_valid, fill_to_dc, busy, mem_req, mem_we;
    logic [15:0]  fill_addr, mem_addr, mem_wdata, mem_rdata;
    logic [127:0] fill_line;
    logic         mem_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_mode = 0;
    int ack_cnt  = 0;
    bit last_ic  = 1'b1;

    logic [15:0] mem_arr [65536];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } xact_t;
    xact_t exp_q[$];

    cache_miss_handler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dc_miss_req  (dc_miss_req),
        .dc_miss_addr (dc_miss_addr),
        .dc_wb_valid  (dc_wb_valid),
        .dc_wb_addr   (dc_wb_addr),
        .dc_wb_line   (dc_wb_line),
        .ic_miss_req  (ic_miss_req),
        .ic_miss_addr (ic_miss_addr),
        .fill_valid   (fill_valid),
        .fill_to_dc   (fill_to_dc),
        .fill_addr    (fill_addr),
        .fill_line    (fill_line),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ack pattern: 0 = always, 1 = every third cycle, 2 = random
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = (ack_cnt % 3 == 2);
            default: mem_ack = 1'($urandom_range(0, 1));
        endcase
        ack_cnt++;
    end

    // Memory-side monitor: transfer order/content and stability while stalled
    logic        stall_q = 1'b0;
    logic        st_we;
    logic [15:0] st_addr, st_wdata;
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            if (stall_q) begin
                check("stall_addr", mem_addr, st_addr);
                check("stall_we", mem_we, st_we);
                check("stall_wdata", mem_wdata, st_wdata);
            end
            if (mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("xact_expected", exp_q.size() > 0, 1);
                end else begin
                    xact_t x;
                    x = exp_q.pop_front();
                    check("xact_we", mem_we, x.we);
                    check("xact_addr", mem_addr, x.addr);
                    if (x.we) check("xact_wdata", mem_wdata, x.wdata);
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                end
            end
            stall_q  = !mem_ack;
            st_we    = mem_we;
            st_addr  = mem_addr;
            st_wdata = mem_wdata;
        end else begin
            stall_q = 1'b0;
        end
    end

    // Expected transfers and line for one miss, from the memory contents before it starts
    task automatic plan(input logic [15:0] maddr, input bit wb, input logic [15:0] waddr,
                        input logic [127:0] wline, output logic [127:0] eline);
        logic [15:0] mbase, wbase;
        xact_t x;
        mbase = {maddr[15:3], 3'b000};
        wbase = {waddr[15:3], 3'b000};
        eline = '0;
        for (int i = 0; i < 8; i++) begin
            if (wb) begin
                x.we = 1'b1; x.addr = wbase + 16'(i); x.wdata = wline[16*i +: 16];
                exp_q.push_back(x);
            end
        end
        for (int i = 0; i < 8; i++) begin
            x.we = 1'b0; x.addr = mbase + 16'(i); x.wdata = '0;
            exp_q.push_back(x);
            eline[16*i +: 16] = (wb && wbase == mbase) ? wline[16*i +: 16] : mem_arr[mbase + 16'(i)];
        end
    endtask

    // Serve one pending miss; called one time unit after a rising edge with the FSM idle
    task automatic serve(input bit chk_lat, input bit scramble);
        bit           win_dc, wb;
        logic [15:0]  maddr, ebase;
        logic [127:0] eline;
        int           cyc;
        win_dc  = dc_miss_req && (!ic_miss_req || last_ic);
        last_ic = !win_dc;
        wb      = win_dc && dc_wb_valid;
        maddr   = win_dc ? dc_miss_addr : ic_miss_addr;
        ebase   = {maddr[15:3], 3'b000};
        plan(maddr, wb, dc_wb_addr, dc_wb_line, eline);
        cyc = 0;
        @(negedge clk);
        while (!fill_valid && cyc < 300) begin
            if (cyc == 1) check("busy_active", busy, 1);
            if (scramble && cyc == 2 && win_dc) begin
                dc_miss_addr = 16'($urandom); dc_wb_addr = 16'($urandom);
                dc_wb_valid  = 1'($urandom); dc_wb_line = {$urandom, $urandom, $urandom, $urandom};
            end else if (scramble && cyc == 2) begin
                ic_miss_addr = 16'($urandom);
            end
            cyc++;
            @(negedge clk);
        end
        check("fill_seen", fill_valid, 1);
        if (chk_lat) check("fill_latency", 32'(cyc), wb ? 17 : 9);
        check("fill_to_dc", fill_to_dc, win_dc);
        check("fill_addr", fill_addr, ebase);
        check("fill_line", fill_line, eline);
        check("xacts_done", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        if (win_dc) dc_miss_req = 1'b0; else ic_miss_req = 1'b0;
        check("fill_pulse_end", fill_valid, 0);
        check("idle_after_fill", busy, 0);
        check("fill_line_hold", fill_line, eline);
        check("fill_addr_hold", fill_addr, ebase);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'(i);
        rst_n = 1'b0;
        dc_miss_req = 1'b0; dc_miss_addr = '0; dc_wb_valid = 1'b0; dc_wb_addr = '0;
        dc_wb_line = '0; ic_miss_req = 1'b0; ic_miss_addr = '0;

        // 1: reset state
        #22;
        check("rst_fill_valid", fill_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_fill_to_dc", fill_to_dc, 0);
        check("rst_fill_addr", fill_addr, 0);
        check("rst_fill_line", fill_line, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_mem_req", mem_req, 0);

        // 2: icache read-only miss
        ic_miss_addr = 16'h0014; ic_miss_req = 1'b1;
        serve(1, 0);
        check("t2_word0", fill_line[15:0], 16'h0010);
        check("t2_word7", fill_line[127:112], 16'h0017);

        // 3: dcache miss with dirty victim
        dc_miss_addr = 16'h0009; dc_wb_valid = 1'b1; dc_wb_addr = 16'h4009;
        for (int i = 0; i < 8; i++) dc_wb_line[16*i +: 16] = 16'h00A0 + 16'(i);
        dc_miss_req = 1'b1;
        serve(1, 0);
        check("t3_victim_mem", mem_arr[16'h400F], 16'h00A7);

        // 4: simultaneous requests, round-robin in both directions
        for (int r = 0; r < 2; r++) begin
            dc_miss_addr = 16'($urandom); dc_wb_valid = 1'($urandom);
            dc_wb_addr = 16'($urandom); dc_wb_line = {$urandom, $urandom, $urandom, $urandom};
            ic_miss_addr = 16'($urandom);
            dc_miss_req = 1'b1; ic_miss_req = 1'b1;
            serve(1, 0);
            check("t4_second_pending", dc_miss_req ^ ic_miss_req, 1);
            serve(1, 0);
        end

        // 5: stalled handshake, ack every third cycle
        ack_mode = 1;
        for (int r = 0; r < 3; r++) begin
            dc_miss_addr = 16'($urandom); dc_wb_valid = 1'b1;
            dc_wb_addr = 16'($urandom); dc_wb_line = {$urandom, $urandom, $urandom, $urandom};
            dc_miss_req = 1'b1;
            serve(0, 0);
        end

        // 6: reset after four read acks, then the held request restarts from word 0
        ack_mode = 0;
        begin
            logic [127:0] dummy;
            ic_miss_addr = 16'h1234; ic_miss_req = 1'b1;
            last_ic = 1'b1;
            plan(ic_miss_addr, 1'b0, '0, '0, dummy);
            repeat (5) @(negedge clk);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("abort_mem_req", mem_req, 0);
            check("abort_busy", busy, 0);
            check("abort_fill_valid", fill_valid, 0);
            check("abort_mem_addr", mem_addr, 0);
            exp_q.delete();
            last_ic = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check("abort_no_fill", fill_valid, 0);
            end
            @(posedge clk); #1 rst_n = 1'b1;
            serve(1, 0);
        end

        // 7: random traffic with random ack timing and field changes after grant
        ack_mode = 2;
        for (int k = 0; k < 12; k++) begin
            dc_miss_addr = 16'($urandom); ic_miss_addr = 16'($urandom);
            dc_wb_valid  = 1'($urandom);
            dc_wb_addr   = ($urandom_range(0, 3) == 0) ? dc_miss_addr ^ 16'h0005 : 16'($urandom);
            dc_wb_line   = {$urandom, $urandom, $urandom, $urandom};
            dc_miss_req  = 1'($urandom);
            ic_miss_req  = !dc_miss_req || 1'($urandom);
            while (dc_miss_req || ic_miss_req) serve(0, 1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
